sram_cmd_arbiter: RTL and testbench

SRAM_CMD_ARBITER -- requirements
Module: sram_cmd_arbiter

---
 rtl/sram_arb_pkg.sv | 16 +
 rtl/sram_arb_rr2.sv | 44 ++++
 rtl/sram_cmd_arbiter.sv | 163 ++++++++++++++++
 tb/tb_sram_cmd_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM command arbiter.
// The optional response watchdog is enabled by SRAM_ARB_TIMEOUT_EN.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_e;

  localparam int CMD_READ  = 2;
  localparam int CMD_WRITE = 3;

  localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

endpackage

// File: rtl/sram_arb_rr2.sv
// Two-way round-robin pick with a priority pointer.
// The pointer moves to favour the other client when the owner completes.
module sram_arb_rr2
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       owner,
  output logic [1:0] gnt
);

  logic prio_q;
  logic prio_d;
  logic win0;
  logic win1;

  assign win0 = req[0] && (!req[1] || !prio_q);
  assign win1 = req[1] && (!req[0] ||  prio_q);

  // Priority pointer: favour the client that did not just complete.
  always_comb begin
    prio_d = prio_q;
    if (upd) prio_d = ~owner;
  end

  // Pointer register; reset favours client 0.
  always_ff @(posedge clk) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end

  // One-hot pick; the two win terms are mutually exclusive.
  always_comb begin
    gnt = '0;
    unique case (1'b1)
      win0:    gnt = 2'b01;
      win1:    gnt = 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/sram_cmd_arbiter.sv
// Arbitrates two clients onto a single SRAM command/response port.
// Define SRAM_ARB_TIMEOUT_EN to add the WAIT_RSP response watchdog.
module sram_cmd_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int CMD_W          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              c0_req_valid,
  input  logic [CMD_W-1:0]  c0_cmd,
  input  logic [DATA_W-1:0] c0_data,
  output logic              c0_req_ready,
  output logic              c0_rsp_valid,
  output logic [DATA_W-1:0] c0_rsp_data,
  input  logic              c1_req_valid,
  input  logic [CMD_W-1:0]  c1_cmd,
  input  logic [DATA_W-1:0] c1_data,
  output logic              c1_req_ready,
  output logic              c1_rsp_valid,
  output logic [DATA_W-1:0] c1_rsp_data,
  output logic              sram_cmd_valid,
  output logic [CMD_W-1:0]  sram_cmd,
  output logic [DATA_W-1:0] sram_data,
  input  logic              sram_cmd_ready,
  input  logic              sram_rsp_valid,
  input  logic [DATA_W-1:0] sram_rsp_data,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  arb_state_e        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        rsp_vld_q, rsp_vld_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]        req_vec;
  logic [1:0]        pick;
  logic              done;
  logic              tmo;

  // Accept only in IDLE and not in the completion cycle, giving a t+3 turnaround.
  assign req_vec = {c1_req_valid, c0_req_valid}
                 & {2{(state_q == IDLE) && !(|rsp_vld_q)}};

  sram_arb_rr2 u_rr (
    .clk   (CLK),
    .rst_n (RESETN),
    .req   (req_vec),
    .upd   (done),
    .owner (grant_q[1]),
    .gnt   (pick)
  );

`ifdef SRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             terr_q, terr_d;

  assign tmo = (state_q == WAIT_RSP) && !sram_rsp_valid
            && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count cycles spent in WAIT_RSP; the error flag is sticky.
  always_comb begin
    cnt_d  = '0;
    terr_d = terr_q | tmo;
    if (state_q == WAIT_RSP) cnt_d = cnt_q + CNT_W'(1);
  end

  // Watchdog registers.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state logic: accept, issue, wait, then complete to the owner.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    rsp_vld_d  = '0;
    rsp_data_d = '0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|pick) begin
          grant_d = pick;
          cmd_d   = pick[1] ? c1_cmd  : c0_cmd;
          data_d  = pick[1] ? c1_data : c0_data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (sram_cmd_ready) begin
          if (cmd_q == CMD_W'(CMD_READ)) state_d = WAIT_RSP;
          else                           done    = 1'b1;
        end
      end
      WAIT_RSP: begin
        if (sram_rsp_valid) begin
          done       = 1'b1;
          rsp_data_d = sram_rsp_data;
        end else if (tmo) begin
          done       = 1'b1;
          rsp_data_d = DATA_W'(TIMEOUT_DATA);
        end
      end
      default: state_d = IDLE;
    endcase
    if (done) begin
      rsp_vld_d = grant_q;
      grant_d   = '0;
      state_d   = IDLE;
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      cmd_q      <= '0;
      data_q     <= '0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign c0_req_ready   = pick[0] & RESETN;
  assign c1_req_ready   = pick[1] & RESETN;
  assign c0_rsp_valid   = rsp_vld_q[0];
  assign c1_rsp_valid   = rsp_vld_q[1];
  assign c0_rsp_data    = rsp_vld_q[0] ? rsp_data_q : '0;
  assign c1_rsp_data    = rsp_vld_q[1] ? rsp_data_q : '0;
  assign sram_cmd_valid = (state_q == ISSUE);
  assign sram_cmd       = (state_q == ISSUE) ? cmd_q  : '0;
  assign sram_data      = (state_q == ISSUE) ? data_q : '0;
  assign grant          = grant_q;

endmodule

// File: tb/tb_sram_cmd_arbiter.sv
// Scoreboard bench for sram_cmd_arbiter.
// Watchdog checks run when SRAM_ARB_TIMEOUT_EN is defined.
module tb_sram_cmd_arbiter;

  logic        CLK;
  logic        RESETN;
  logic        c0_req_valid, c1_req_valid;
  logic [3:0]  c0_cmd, c1_cmd;
  logic [15:0] c0_data, c1_data;
  logic        c0_req_ready, c1_req_ready;
  logic        c0_rsp_valid, c1_rsp_valid;
  logic [15:0] c0_rsp_data, c1_rsp_data;
  logic        sram_cmd_valid;
  logic [3:0]  sram_cmd;
  logic [15:0] sram_data;
  logic        sram_cmd_ready;
  logic        sram_rsp_valid;
  logic [15:0] sram_rsp_data;
  logic [1:0]  grant;
  logic        timeout_err;

  sram_cmd_arbiter #(
    .DATA_W(16), .CMD_W(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .CLK(CLK), .RESETN(RESETN),
    .c0_req_valid(c0_req_valid), .c0_cmd(c0_cmd), .c0_data(c0_data),
    .c0_req_ready(c0_req_ready), .c0_rsp_valid(c0_rsp_valid),
    .c0_rsp_data(c0_rsp_data),
    .c1_req_valid(c1_req_valid), .c1_cmd(c1_cmd), .c1_data(c1_data),
    .c1_req_ready(c1_req_ready), .c1_rsp_valid(c1_rsp_valid),
    .c1_rsp_data(c1_rsp_data),
    .sram_cmd_valid(sram_cmd_valid), .sram_cmd(sram_cmd),
    .sram_data(sram_data), .sram_cmd_ready(sram_cmd_ready),
    .sram_rsp_valid(sram_rsp_valid), .sram_rsp_data(sram_rsp_data),
    .grant(grant), .timeout_err(timeout_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct { logic [3:0] cmd; logic [15:0] data; } cmd_t;
  typedef struct { int cl; logic [15:0] data; } rsp_t;

  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];
  cmd_t mc;
  rsp_t mr;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got an output, required none", name);
  endtask

  function automatic logic [63:0] outs();
    return {4'b0, c0_req_ready, c1_req_ready, c0_rsp_valid, c1_rsp_valid,
            c0_rsp_data, c1_rsp_data, sram_cmd_valid, sram_cmd,
            sram_data, grant, timeout_err};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_cmd(input logic [3:0] c, input logic [15:0] d);
    cmd_t e;
    e.cmd  = c;
    e.data = d;
    exp_cmd.push_back(e);
  endtask

  task automatic push_rsp(input int cl, input logic [15:0] d);
    rsp_t e;
    e.cl   = cl;
    e.data = d;
    exp_rsp.push_back(e);
  endtask

  task automatic wait_accept(input int cl);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if ((cl == 1) ? c1_req_ready : c0_req_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(cl == 1 ? "accept_c1" : "accept_c0", ok, 1);
  endtask

  task automatic drain();
    int left;
    left = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      left = exp_cmd.size() + exp_rsp.size();
      if (left == 0) break;
      tick();
    end
    chk("drain", left, 0);
  endtask

  // Monitor: compare SRAM handshakes and client responses to the queues.
  always @(negedge CLK) begin
    if (RESETN) begin
      if (sram_cmd_valid && sram_cmd_ready) begin
        if (exp_cmd.size() == 0) miss("unexpected_cmd");
        else begin
          mc = exp_cmd.pop_front();
          chk("sram_cmd", sram_cmd, mc.cmd);
          chk("sram_data", sram_data, mc.data);
        end
      end
      if (c0_rsp_valid || c1_rsp_valid) begin
        chk("rsp_single", c0_rsp_valid & c1_rsp_valid, 0);
        chk("grant_clr", grant, 0);
        if (exp_rsp.size() == 0) miss("unexpected_rsp");
        else begin
          mr = exp_rsp.pop_front();
          chk("rsp_client", c1_rsp_valid, mr.cl);
          chk("rsp_data", c1_rsp_valid ? c1_rsp_data : c0_rsp_data,
              mr.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    RESETN = 0;
    c0_req_valid = 0; c0_cmd = 0; c0_data = 0;
    c1_req_valid = 0; c1_cmd = 0; c1_data = 0;
    sram_cmd_ready = 0; sram_rsp_valid = 0; sram_rsp_data = 0;
    repeat (3) tick();
    @(negedge CLK);
    chk("reset_outs", outs(), 0);

    // Write from c0, immediately ready; first cycle after release.
    tick();
    RESETN = 1;
    sram_cmd_ready = 1;
    c0_req_valid = 1; c0_cmd = 4'd3; c0_data = 16'h1234;
    push_cmd(4'd3, 16'h1234);
    push_rsp(0, 16'h0000);
    @(negedge CLK);
    chk("first_accept", c0_req_ready, 1);
    tick();
    c0_req_valid = 0;
    @(negedge CLK);
    chk("issue_valid", sram_cmd_valid, 1);
    chk("issue_grant", grant, 2'b01);

    // c1 read offered during the completion cycle.
    tick();
    c1_req_valid = 1; c1_cmd = 4'd2; c1_data = 16'h0000;
    push_cmd(4'd2, 16'h0000);
    push_rsp(1, 16'hBEEF);
    @(negedge CLK);
    chk("wr_rsp_valid", c0_rsp_valid, 1);
    chk("turnaround_block", c1_req_ready, 0);
    tick();
    @(negedge CLK);
    chk("accept_t3", c1_req_ready, 1);
    tick();
    c1_req_valid = 0;
    @(negedge CLK);
    chk("rd_grant", grant, 2'b10);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge CLK);
      chk("rd_wait_norsp", c1_rsp_valid, 0);
      chk("rd_wait_grant", grant, 2'b10);
    end
    tick();
    sram_rsp_valid = 1; sram_rsp_data = 16'hBEEF;
    @(negedge CLK);
    chk("rd_lat_0", c1_rsp_valid, 0);
    tick();
    sram_rsp_valid = 0;
    @(negedge CLK);
    chk("rd_lat_1", c1_rsp_valid, 1);
    chk("rd_grant_clr", grant, 0);

    // Stray SRAM response while idle.
    tick();
    sram_rsp_valid = 1; sram_rsp_data = 16'h7777;
    @(negedge CLK);
    tick();
    sram_rsp_valid = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("stray_ignored", {c0_rsp_valid, c1_rsp_valid}, 0);
      tick();
    end

    // Back-pressure: command must hold and c1 must wait.
    sram_cmd_ready = 0;
    c0_req_valid = 1; c0_cmd = 4'd3; c0_data = 16'hABCD;
    push_cmd(4'd3, 16'hABCD);
    push_rsp(0, 16'h0000);
    wait_accept(0);
    tick();
    c0_req_valid = 0;
    c1_req_valid = 1; c1_cmd = 4'd4; c1_data = 16'h5555;
    push_cmd(4'd4, 16'h5555);
    push_rsp(1, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("hold_cmd", {sram_cmd_valid, sram_cmd, sram_data},
          {1'b1, 4'd3, 16'hABCD});
      chk("hold_no_accept", {c0_req_ready, c1_req_ready}, 0);
      tick();
    end
    sram_cmd_ready = 1;
    wait_accept(1);
    tick();
    c1_req_valid = 0;
    drain();

    // Both clients requesting from reset: grants alternate.
    tick();
    RESETN = 0;
    c0_req_valid = 1; c0_cmd = 4'd3; c0_data = 16'hA0A0;
    c1_req_valid = 1; c1_cmd = 4'd3; c1_data = 16'hB1B1;
    for (int i = 0; i < 4; i++) begin
      push_cmd(4'd3, (i % 2 == 0) ? 16'hA0A0 : 16'hB1B1);
      push_rsp(i % 2, 16'h0000);
    end
    tick();
    tick();
    RESETN = 1;
    acc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (c0_req_ready || c1_req_ready) begin
        if (acc == 0) chk("rr_first_cycle", i, 0);
        chk("rr_single", c0_req_ready & c1_req_ready, 0);
        chk("rr_order", c1_req_ready, acc % 2);
        acc++;
        if (acc == 4) break;
      end
      tick();
    end
    chk("rr_count", acc, 4);
    tick();
    c0_req_valid = 0;
    c1_req_valid = 0;
    drain();

    // Reset during WAIT_RSP abandons the read.
    tick();
    c0_req_valid = 1; c0_cmd = 4'd2; c0_data = 16'h0042;
    push_cmd(4'd2, 16'h0042);
    wait_accept(0);
    tick();
    c0_req_valid = 0;
    @(negedge CLK);
    tick();
    tick();
    @(negedge CLK);
    chk("wait_grant", grant, 2'b01);
    tick();
    RESETN = 0;
    tick();
    RESETN = 1;
    @(negedge CLK);
    chk("rst_wait_outs", outs(), 0);
    tick();
    sram_rsp_valid = 1; sram_rsp_data = 16'h1111;
    @(negedge CLK);
    tick();
    sram_rsp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("rst_no_rsp", {c0_rsp_valid, c1_rsp_valid, grant}, 0);
      tick();
    end

`ifdef SRAM_ARB_TIMEOUT_EN
    // Read with no response: watchdog completes with DEAD.
    c1_req_valid = 1; c1_cmd = 4'd2; c1_data = 16'h0000;
    push_cmd(4'd2, 16'h0000);
    push_rsp(1, 16'hDEAD);
    wait_accept(1);
    tick();
    c1_req_valid = 0;
    @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      tick();
      @(negedge CLK);
      chk("tmo_wait", {c1_rsp_valid, timeout_err}, 0);
    end
    tick();
    @(negedge CLK);
    chk("tmo_rsp", c1_rsp_valid, 1);
    chk("tmo_err", timeout_err, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge CLK);
      chk("tmo_sticky", timeout_err, 1);
    end
`else
    @(negedge CLK);
    chk("tmo_tied", timeout_err, 0);
`endif

    tick();
    @(negedge CLK);
    chk("queues_empty", exp_cmd.size() + exp_rsp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
